// File: rtl/wrapper_stim_pkg.sv
// wrapper_stim_pkg: shared definitions for the wrapper stimulus sequencer.
// Holds the replay FSM state encoding, the field layout of a packed
// schedule entry {hold, PB, DIP}, and a constant clog2 helper used to size
// addresses and FIFO pointers.
package wrapper_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The DIP field always sits at the bottom of a schedule entry.
  localparam int DIP_LSB = 0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int pbLsb(input int nDips);
    return nDips;
  endfunction

  function automatic int holdLsb(input int nDips, input int nPbs);
    return nDips + nPbs;
  endfunction

endpackage

// File: rtl/stim_fifo.sv
// stim_fifo: small synchronous FIFO used for console input and for console
// output capture. Pointers carry one extra wrap bit so full and empty can
// be told apart. A push into a full FIFO is still accepted when a pop
// happens on the same edge, because that pop frees the slot being written.
module stim_fifo
  import wrapper_stim_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_popOk;
  logic             w_pushOk;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) && (r_wrPtr[AW] != r_rdPtr[AW]);
  assign w_popOk  = i_pop && !o_empty;
  assign w_pushOk = i_push && (!o_full || w_popOk);
  assign o_dout   = r_mem[r_rdPtr[AW-1:0]];

  // Storage has no reset; only slots behind the write pointer are ever read.
  always_ff @(posedge i_clk) begin
    if (w_pushOk) r_mem[r_wrPtr[AW-1:0]] <= i_din;
  end

  // Pointer advance; both pointers wrap naturally through the extra bit.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_popOk)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/wrapper_stim_seq.sv
// wrapper_stim_seq: stimulus and monitor engine for a Wrapper-class DUT.
// Replays a programmed table of DIP/PB steps, each held for max(hold,1)
// cycles, feeds console input bytes to the DUT through a valid/ack FIFO and
// captures console output bytes through a ready/valid FIFO.
// Optional build macro WRAPPER_STIM_LOOP_EN adds a LOOP input that restarts
// the schedule from step 0 after the last step, pulsing DONE once per pass.
module wrapper_stim_seq
  import wrapper_stim_pkg::*;
#(
  parameter int N_DIPs    = 16,
  parameter int N_PBs     = 4,
  parameter int N_STEPS   = 8,
  parameter int DLY_W     = 16,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                             CLK,
  input  logic                             RESETn,
  input  logic                             TBL_WE,
  input  logic [clog2(N_STEPS)-1:0]        TBL_ADDR,
  input  logic [N_DIPs+N_PBs+DLY_W-1:0]    TBL_DATA,
  input  logic [clog2(N_STEPS):0]          STEP_COUNT,
  input  logic                             START,
  input  logic                             ABORT,
`ifdef WRAPPER_STIM_LOOP_EN
  input  logic                             LOOP,
`endif
  output logic [N_DIPs-1:0]                DIP,
  output logic [N_PBs-1:0]                 PB,
  output logic                             BUSY,
  output logic                             DONE,
  input  logic                             CIN_PUSH,
  input  logic [7:0]                       CIN_BYTE,
  output logic [7:0]                       CONSOLE_IN,
  output logic                             CONSOLE_IN_valid,
  input  logic                             CONSOLE_IN_ack,
  input  logic [7:0]                       CONSOLE_OUT,
  input  logic                             CONSOLE_OUT_valid,
  output logic                             CONSOLE_OUT_ready,
  input  logic                             COUT_POP,
  output logic [7:0]                       COUT_BYTE,
  output logic                             COUT_EMPTY,
  output logic                             CIN_OVF
);

  localparam int SW       = clog2(N_STEPS);
  localparam int TW       = N_DIPs + N_PBs + DLY_W;
  localparam int PB_LSB   = pbLsb(N_DIPs);
  localparam int HOLD_LSB = holdLsb(N_DIPs, N_PBs);

  logic [TW-1:0]     r_table [N_STEPS];
  state_t            r_state;
  logic [SW-1:0]     r_stepIdx;
  logic [DLY_W-1:0]  r_cnt;
  logic [N_DIPs-1:0] r_dip;
  logic [N_PBs-1:0]  r_pb;
  logic              r_busy;
  logic              r_done;
  logic              r_cinOvf;

  logic              w_expire;
  logic              w_lastStep;
  logic [TW-1:0]     w_loadEntry;
  logic              w_cinFull;
  logic              w_cinEmpty;
  logic              w_cinPop;
  logic              w_coutFull;

  // A count of 1 or 0 means the current step is on its final visible cycle,
  // which is how a hold of zero ends up shown for a single cycle.
  assign w_expire   = (r_cnt <= DLY_W'(1));
  assign w_lastStep = (({1'b0, r_stepIdx} + (SW+1)'(1)) >= STEP_COUNT)
                    || (r_stepIdx == SW'(N_STEPS - 1));
  assign w_loadEntry = ((r_state == ST_HOLD) && !w_lastStep)
                     ? r_table[r_stepIdx + SW'(1)]
                     : r_table[0];

  assign DIP  = r_dip;
  assign PB   = r_pb;
  assign BUSY = r_busy;
  assign DONE = r_done;

  // Schedule table is host-writable only while no replay is running.
  always_ff @(posedge CLK) begin
    if (TBL_WE && !r_busy) r_table[TBL_ADDR] <= TBL_DATA;
  end

  // Replay FSM: loads steps back-to-back, pulses DONE at the end of a pass,
  // and lets ABORT return to idle from anywhere with outputs frozen.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state   <= ST_IDLE;
      r_stepIdx <= '0;
      r_cnt     <= '0;
      r_dip     <= '0;
      r_pb      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ABORT) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START) begin
              if (STEP_COUNT != '0) begin
                r_dip     <= w_loadEntry[DIP_LSB +: N_DIPs];
                r_pb      <= w_loadEntry[PB_LSB +: N_PBs];
                r_cnt     <= w_loadEntry[HOLD_LSB +: DLY_W];
                r_stepIdx <= '0;
                r_busy    <= 1'b1;
                r_state   <= ST_HOLD;
              end else begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end
          end
          ST_HOLD: begin
            if (w_expire) begin
              if (!w_lastStep) begin
                r_dip     <= w_loadEntry[DIP_LSB +: N_DIPs];
                r_pb      <= w_loadEntry[PB_LSB +: N_PBs];
                r_cnt     <= w_loadEntry[HOLD_LSB +: DLY_W];
                r_stepIdx <= r_stepIdx + SW'(1);
              end
`ifdef WRAPPER_STIM_LOOP_EN
              else if (LOOP) begin
                r_dip     <= w_loadEntry[DIP_LSB +: N_DIPs];
                r_pb      <= w_loadEntry[PB_LSB +: N_PBs];
                r_cnt     <= w_loadEntry[HOLD_LSB +: DLY_W];
                r_stepIdx <= '0;
                r_done    <= 1'b1;
              end
`endif
              else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
            end else begin
              r_cnt <= r_cnt - DLY_W'(1);
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign CONSOLE_IN_valid = !w_cinEmpty;
  assign w_cinPop         = CONSOLE_IN_ack && !w_cinEmpty;

  // Sticky overflow: a push was lost because the input FIFO was full and
  // nothing was popped on the same edge to make room.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cinOvf <= 1'b0;
    end else if (CIN_PUSH && w_cinFull && !w_cinPop) begin
      r_cinOvf <= 1'b1;
    end
  end

  assign CIN_OVF = r_cinOvf;

  stim_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_cinFifo (
    .i_clk   (CLK),
    .i_rstN  (RESETn),
    .i_push  (CIN_PUSH),
    .i_din   (CIN_BYTE),
    .i_pop   (CONSOLE_IN_ack),
    .o_dout  (CONSOLE_IN),
    .o_full  (w_cinFull),
    .o_empty (w_cinEmpty)
  );

  assign CONSOLE_OUT_ready = !w_coutFull;

  stim_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_coutFifo (
    .i_clk   (CLK),
    .i_rstN  (RESETn),
    .i_push  (CONSOLE_OUT_valid),
    .i_din   (CONSOLE_OUT),
    .i_pop   (COUT_POP),
    .o_dout  (COUT_BYTE),
    .o_full  (w_coutFull),
    .o_empty (COUT_EMPTY)
  );

endmodule

// File: tb/tb_wrapper_stim_seq.sv
// tb_wrapper_stim_seq: self-checking bench for wrapper_stim_seq.
// Schedules are expanded into a per-cycle list of expected DIP/PB values and
// the console FIFOs are tracked with byte queues, both driven with random
// data. Inputs change 1ns after a rising edge, outputs are read on the
// falling edge.
module tb_wrapper_stim_seq;

  logic        CLK;
  logic        RESETn;
  logic        TBL_WE;
  logic [2:0]  TBL_ADDR;
  logic [35:0] TBL_DATA;
  logic [3:0]  STEP_COUNT;
  logic        START;
  logic        ABORT;
`ifdef WRAPPER_STIM_LOOP_EN
  logic        LOOP;
`endif
  logic [15:0] DIP;
  logic [3:0]  PB;
  logic        BUSY;
  logic        DONE;
  logic        CIN_PUSH;
  logic [7:0]  CIN_BYTE;
  logic [7:0]  CONSOLE_IN;
  logic        CONSOLE_IN_valid;
  logic        CONSOLE_IN_ack;
  logic [7:0]  CONSOLE_OUT;
  logic        CONSOLE_OUT_valid;
  logic        CONSOLE_OUT_ready;
  logic        COUT_POP;
  logic [7:0]  COUT_BYTE;
  logic        COUT_EMPTY;
  logic        CIN_OVF;

  int vectors;
  int miscompares;

  logic [15:0] sHold [8];
  logic [15:0] sDip  [8];
  logic [3:0]  sPb   [8];
  logic [15:0] modelDip;
  logic [3:0]  modelPb;

  wrapper_stim_seq dut (
    .CLK               (CLK),
    .RESETn            (RESETn),
    .TBL_WE            (TBL_WE),
    .TBL_ADDR          (TBL_ADDR),
    .TBL_DATA          (TBL_DATA),
    .STEP_COUNT        (STEP_COUNT),
    .START             (START),
    .ABORT             (ABORT),
`ifdef WRAPPER_STIM_LOOP_EN
    .LOOP              (LOOP),
`endif
    .DIP               (DIP),
    .PB                (PB),
    .BUSY              (BUSY),
    .DONE              (DONE),
    .CIN_PUSH          (CIN_PUSH),
    .CIN_BYTE          (CIN_BYTE),
    .CONSOLE_IN        (CONSOLE_IN),
    .CONSOLE_IN_valid  (CONSOLE_IN_valid),
    .CONSOLE_IN_ack    (CONSOLE_IN_ack),
    .CONSOLE_OUT       (CONSOLE_OUT),
    .CONSOLE_OUT_valid (CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready (CONSOLE_OUT_ready),
    .COUT_POP          (COUT_POP),
    .COUT_BYTE         (COUT_BYTE),
    .COUT_EMPTY        (COUT_EMPTY),
    .CIN_OVF           (CIN_OVF)
  );

  // Free-running 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic writeStep(input int addr, input logic [15:0] hold,
                           input logic [3:0] pb, input logic [15:0] dip);
    @(posedge CLK);
    #1;
    TBL_WE   = 1'b1;
    TBL_ADDR = 3'(addr);
    TBL_DATA = {hold, pb, dip};
    @(posedge CLK);
    #1;
    TBL_WE = 1'b0;
  endtask

  task automatic loadSchedule(input int n);
    for (int i = 0; i < n; i++) writeStep(i, sHold[i], sPb[i], sDip[i]);
  endtask

  task automatic applyStimulus(input int n);
    @(posedge CLK);
    #1;
    START      = 1'b1;
    STEP_COUNT = 4'(n);
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Expands the schedule into one expected {PB,DIP} per cycle, then checks
  // the replay cycle by cycle, the DONE pulse and the idle tail.
  task automatic runSchedule(input string name, input int n, input bit pokeTable);
    logic [15:0] qDip [$];
    logic [3:0]  qPb [$];
    logic [21:0] expV;
    logic [21:0] obsV;
    int hv;
    for (int s = 0; s < n; s++) begin
      hv = (sHold[s] == 16'd0) ? 1 : int'(sHold[s]);
      repeat (hv) begin
        qDip.push_back(sDip[s]);
        qPb.push_back(sPb[s]);
      end
    end
    applyStimulus(n);
    for (int c = 0; c < qDip.size(); c++) begin
      @(negedge CLK);
      if (pokeTable && c == 2) begin
        TBL_WE   = 1'b1;
        TBL_ADDR = 3'd1;
        TBL_DATA = {16'd1, 4'hF, 16'hDEAD};
      end
      if (pokeTable && c == 3) TBL_WE = 1'b0;
      expV = {1'b1, 1'b0, qPb[c], qDip[c]};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL %s replay cycle %0d: {BUSY,DONE,PB,DIP} got %h expected %h", name, c, obsV, expV);
      end
    end
    if (n > 0) begin
      modelDip = sDip[n-1];
      modelPb  = sPb[n-1];
    end
    @(negedge CLK);
    expV = {1'b0, 1'b1, modelPb, modelDip};
    obsV = {BUSY, DONE, PB, DIP};
    vectors++;
    if (obsV !== expV) begin
      miscompares++;
      $display("[TB] FAIL %s done pulse: got %h expected %h", name, obsV, expV);
    end
    repeat (3) begin
      @(negedge CLK);
      expV = {1'b0, 1'b0, modelPb, modelDip};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL %s idle after done: got %h expected %h", name, obsV, expV);
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] expV;
    logic [25:0] obsV;
    logic [17:0] runV;
    expV = {16'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge CLK);
    obsV = {DIP, PB, BUSY, DONE, CONSOLE_IN_valid, CONSOLE_OUT_ready, COUT_EMPTY, CIN_OVF};
    vectors++;
    if (obsV !== expV) begin
      miscompares++;
      $display("[TB] FAIL reset_initial: got %h expected %h", obsV, expV);
    end
    RESETn = 1'b1;
    @(negedge CLK);
    obsV = {DIP, PB, BUSY, DONE, CONSOLE_IN_valid, CONSOLE_OUT_ready, COUT_EMPTY, CIN_OVF};
    vectors++;
    if (obsV !== expV) begin
      miscompares++;
      $display("[TB] FAIL reset_released: got %h expected %h", obsV, expV);
    end
    sHold[0] = 16'd41;
    sDip[0]  = 16'h55AA;
    sPb[0]   = 4'h9;
    loadSchedule(1);
    @(posedge CLK);
    #1;
    START             = 1'b1;
    STEP_COUNT        = 4'd1;
    CIN_PUSH          = 1'b1;
    CIN_BYTE          = 8'h77;
    CONSOLE_OUT_valid = 1'b1;
    CONSOLE_OUT       = 8'h88;
    @(posedge CLK);
    #1;
    START             = 1'b0;
    CIN_PUSH          = 1'b0;
    CONSOLE_OUT_valid = 1'b0;
    repeat (5) @(negedge CLK);
    runV = {BUSY, DIP, CONSOLE_IN_valid};
    vectors++;
    if (runV !== {1'b1, 16'h55AA, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_prehold: got %h expected %h", runV, {1'b1, 16'h55AA, 1'b1});
    end
    #2;
    RESETn = 1'b0;
    #1;
    obsV = {DIP, PB, BUSY, DONE, CONSOLE_IN_valid, CONSOLE_OUT_ready, COUT_EMPTY, CIN_OVF};
    vectors++;
    if (obsV !== expV) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_hold_async: got %h expected %h", obsV, expV);
    end
    @(negedge CLK);
    RESETn   = 1'b1;
    modelDip = 16'h0;
    modelPb  = 4'h0;
    repeat (2) @(negedge CLK);
    obsV = {DIP, PB, BUSY, DONE, CONSOLE_IN_valid, CONSOLE_OUT_ready, COUT_EMPTY, CIN_OVF};
    vectors++;
    if (obsV !== expV) begin
      miscompares++;
      $display("[TB] FAIL reset_after_mid_hold: got %h expected %h", obsV, expV);
    end
  endtask

  task automatic test_schedule();
    sHold[0] = 16'd41; sDip[0] = 16'h001A; sPb[0] = 4'h0;
    sHold[1] = 16'd60; sDip[1] = 16'h001D; sPb[1] = 4'h0;
    loadSchedule(2);
    runSchedule("schedule_two_step", 2, 1'b1);
  endtask

  task automatic test_hold_zero();
    sHold[0] = 16'd2; sDip[0] = 16'h1111; sPb[0] = 4'h1;
    sHold[1] = 16'd0; sDip[1] = 16'h2222; sPb[1] = 4'h2;
    sHold[2] = 16'd1; sDip[2] = 16'h3333; sPb[2] = 4'h4;
    sHold[3] = 16'd0; sDip[3] = 16'h4444; sPb[3] = 4'h8;
    loadSchedule(4);
    runSchedule("hold_zero", 4, 1'b0);
  endtask

  task automatic test_random_schedule();
    int n;
    for (int it = 0; it < 6; it++) begin
      n = (it == 0) ? 0 : int'($urandom_range(1, 8));
      for (int s = 0; s < 8; s++) begin
        sHold[s] = 16'($urandom_range(0, 4));
        sDip[s]  = 16'($urandom);
        sPb[s]   = 4'($urandom);
      end
      loadSchedule(8);
      runSchedule("random_schedule", n, 1'b0);
    end
  endtask

  task automatic test_abort();
    logic [21:0] expV;
    logic [21:0] obsV;
    sHold[0] = 16'd41; sDip[0] = 16'h0ACE; sPb[0] = 4'h3;
    loadSchedule(1);
    applyStimulus(1);
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      expV = {1'b1, 1'b0, 4'h3, 16'h0ACE};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL abort_prehold cycle %0d: got %h expected %h", c, obsV, expV);
      end
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    for (int c = 0; c < 40; c++) begin
      expV = {1'b0, 1'b0, 4'h3, 16'h0ACE};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL abort_idle cycle %0d: got %h expected %h", c, obsV, expV);
      end
      @(negedge CLK);
    end
    modelDip = 16'h0ACE;
    modelPb  = 4'h3;
    @(posedge CLK);
    #1;
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      expV = {1'b0, 1'b0, modelPb, modelDip};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL abort_beats_start: got %h expected %h", obsV, expV);
      end
    end
  endtask

  task automatic test_console_in();
    logic [7:0]  q [$];
    logic        ovf;
    logic        push;
    logic        ack;
    logic        popOk;
    logic        pushOk;
    logic [7:0]  b;
    logic [9:0]  obsV;
    logic [9:0]  expV;
    logic [23:0] got;
    ovf = 1'b0;
    got = 24'h0;
    for (int c = 0; c < 96; c++) begin
      if (c < 14) begin
        push = (c < 3);
        b    = 8'h41 + 8'(c);
        ack  = (c % 2 == 1);
      end else if (c < 24) begin
        push = (c < 23);
        b    = 8'($urandom);
        ack  = 1'b0;
      end else if (c < 36) begin
        push = 1'b0;
        b    = 8'h00;
        ack  = 1'b1;
      end else begin
        push = 1'($urandom);
        b    = 8'($urandom);
        ack  = 1'($urandom);
      end
      @(posedge CLK);
      #1;
      CIN_PUSH       = push;
      CIN_BYTE       = b;
      CONSOLE_IN_ack = ack;
      @(negedge CLK);
      expV = {q.size() > 0, ovf, (q.size() > 0) ? q[0] : 8'h00};
      obsV = {CONSOLE_IN_valid, CIN_OVF, (q.size() > 0) ? CONSOLE_IN : 8'h00};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL console_in cycle %0d: {valid,ovf,byte} got %h expected %h", c, obsV, expV);
      end
      popOk  = ack && (q.size() > 0);
      pushOk = push && ((q.size() < 8) || popOk);
      if (push && !pushOk) ovf = 1'b1;
      if (popOk) begin
        if (c < 14) got = {got[15:0], q[0]};
        void'(q.pop_front());
      end
      if (pushOk) q.push_back(b);
      if (c == 13) begin
        vectors++;
        if (got !== 24'h414243) begin
          miscompares++;
          $display("[TB] FAIL console_in_order: got %h expected %h", got, 24'h414243);
        end
      end
    end
    @(posedge CLK);
    #1;
    CIN_PUSH       = 1'b0;
    CONSOLE_IN_ack = 1'b0;
  endtask

  task automatic test_console_out();
    logic [7:0] q [$];
    logic       valid;
    logic       pop;
    logic       popOk;
    logic       pushOk;
    logic [7:0] b;
    logic [9:0] obsV;
    logic [9:0] expV;
    for (int c = 0; c < 80; c++) begin
      b = 8'($urandom);
      if (c < 8) begin
        valid = 1'b1;
        pop   = 1'b0;
      end else if (c == 8) begin
        valid = 1'b1;
        pop   = 1'b1;
      end else if (c < 19) begin
        valid = 1'b0;
        pop   = 1'b1;
      end else begin
        valid = 1'($urandom);
        pop   = 1'($urandom);
      end
      @(posedge CLK);
      #1;
      CONSOLE_OUT_valid = valid;
      CONSOLE_OUT       = b;
      COUT_POP          = pop;
      @(negedge CLK);
      expV = {q.size() < 8, q.size() == 0, (q.size() > 0) ? q[0] : 8'h00};
      obsV = {CONSOLE_OUT_ready, COUT_EMPTY, (q.size() > 0) ? COUT_BYTE : 8'h00};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL console_out cycle %0d: {ready,empty,byte} got %h expected %h", c, obsV, expV);
      end
      popOk  = pop && (q.size() > 0);
      pushOk = valid && ((q.size() < 8) || popOk);
      if (popOk) void'(q.pop_front());
      if (pushOk) q.push_back(b);
    end
    @(posedge CLK);
    #1;
    CONSOLE_OUT_valid = 1'b0;
    COUT_POP          = 1'b0;
  endtask

`ifdef WRAPPER_STIM_LOOP_EN
  task automatic test_loop();
    logic [21:0] expV;
    logic [21:0] obsV;
    int s;
    sHold[0] = 16'd3; sDip[0] = 16'($urandom); sPb[0] = 4'($urandom);
    sHold[1] = 16'd3; sDip[1] = 16'($urandom); sPb[1] = 4'($urandom);
    loadSchedule(2);
    LOOP = 1'b1;
    applyStimulus(2);
    for (int c = 0; c < 24; c++) begin
      @(negedge CLK);
      s    = (c / 3) % 2;
      expV = {1'b1, (c % 6 == 0) && (c > 0), sPb[s], sDip[s]};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL loop cycle %0d: got %h expected %h", c, obsV, expV);
      end
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    LOOP  = 1'b0;
    repeat (4) begin
      expV = {1'b0, 1'b0, sPb[1], sDip[1]};
      obsV = {BUSY, DONE, PB, DIP};
      vectors++;
      if (obsV !== expV) begin
        miscompares++;
        $display("[TB] FAIL loop_abort: got %h expected %h", obsV, expV);
      end
      @(negedge CLK);
    end
  endtask
`endif

  // Test sequence: every scenario runs in order, then a single summary line.
  initial begin
    vectors           = 0;
    miscompares       = 0;
    modelDip          = 16'h0;
    modelPb           = 4'h0;
    RESETn            = 1'b0;
    TBL_WE            = 1'b0;
    TBL_ADDR          = 3'd0;
    TBL_DATA          = 36'h0;
    STEP_COUNT        = 4'd0;
    START             = 1'b0;
    ABORT             = 1'b0;
`ifdef WRAPPER_STIM_LOOP_EN
    LOOP              = 1'b0;
`endif
    CIN_PUSH          = 1'b0;
    CIN_BYTE          = 8'h00;
    CONSOLE_IN_ack    = 1'b0;
    CONSOLE_OUT       = 8'h00;
    CONSOLE_OUT_valid = 1'b0;
    COUT_POP          = 1'b0;
    $display("[TB] starting wrapper_stim_seq bench");
    test_reset();
    test_schedule();
    test_hold_zero();
    test_random_schedule();
    test_abort();
    test_console_in();
    test_console_out();
`ifdef WRAPPER_STIM_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wrapper_stim_seq.md
Name: wrapper_stim_seq

Overview:
- Parametrised, synthesizable stimulus and monitor engine that drives a Wrapper-class DUT in place of hand-timed initial blocks.
- Replays a programmable table of DIP/PB steps with per-step hold counts.
- Feeds console input bytes through a valid/ack FIFO and captures console output bytes through a ready/valid FIFO.
- Sits between a host bench (or a soft controller) and the DUT I/O.

Parameters:
- N_DIPs, 16, width of the DIP stimulus vector
- N_PBs, 4, width of the pushbutton stimulus vector
- N_STEPS, 8, schedule table depth (power of 2)
- DLY_W, 16, width of the per-step hold counter
- IN_DEPTH, 8, console-input FIFO depth (power of 2)
- OUT_DEPTH, 8, console-output capture FIFO depth (power of 2)

Ports:
- CLK  in  1  single clock
- RESETn  in  1  asynchronous active-low reset
- TBL_WE  in  1  schedule-table write strobe
- TBL_ADDR  in  log2(N_STEPS)  table entry index
- TBL_DATA  in  N_DIPs+N_PBs+DLY_W  packed {hold, PB, DIP}
- STEP_COUNT  in  log2(N_STEPS)+1  number of valid steps
- START  in  1  begin replay (IDLE only)
- ABORT  in  1  stop replay
- DIP  out  N_DIPs  driven DIP value
- PB  out  N_PBs  driven PB value
- BUSY  out  1  replay in progress
- DONE  out  1  one-cycle pulse at end of schedule
- CIN_PUSH  in  1  host push into console-input FIFO
- CIN_BYTE  in  8  byte to push
- CONSOLE_IN  out  8  byte presented to DUT
- CONSOLE_IN_valid  out  1  byte available to DUT
- CONSOLE_IN_ack  in  1  DUT consumed byte
- CONSOLE_OUT  in  8  DUT output byte
- CONSOLE_OUT_valid  in  1  DUT output valid
- CONSOLE_OUT_ready  out  1  capture FIFO can accept
- COUT_POP  in  1  host pop of captured byte
- COUT_BYTE  out  8  head of capture FIFO
- COUT_EMPTY  out  1  capture FIFO empty
- CIN_OVF  out  1  sticky: push dropped because FIFO full

Behaviour:
- Reset (RESETn=0, asynchronous): DIP=0, PB=0, BUSY=0, DONE=0, CONSOLE_IN_valid=0, CONSOLE_OUT_ready=1, COUT_EMPTY=1, CIN_OVF=0; both FIFOs emptied.
- Schedule table is not reset; contents are undefined until written. TBL_WE is ignored while BUSY=1.
- FSM states IDLE, HOLD, DONE.
- IDLE + START + STEP_COUNT>0: on the next edge, load step 0 onto DIP/PB, load counter with hold, set BUSY=1, go to HOLD.
- IDLE + START + STEP_COUNT=0: DONE pulse only; no output change.
- HOLD: every step is visible for exactly max(hold,1) cycles; hold=0 is treated as 1.
- HOLD, counter expires, step index below STEP_COUNT-1: load the next step on the same edge, so step changes are back-to-back.
- HOLD, counter expires after the last step: go to DONE. DIP/PB retain the last values. BUSY drops.
- DONE: DONE=1 for one cycle, then IDLE.
- ABORT in any state: IDLE on the next edge, DIP/PB retained, no DONE pulse. ABORT wins over a simultaneous START.
- Console input: CONSOLE_IN is the FIFO head and CONSOLE_IN_valid = !empty (both combinational from registers).
- Console input pop: occurs on CONSOLE_IN_valid & CONSOLE_IN_ack, and the next byte may be presented the following cycle. Ack while not valid is ignored.
- Console input push: a push while full is dropped and sets CIN_OVF. Simultaneous push and pop on a full FIFO both succeed.
- Console output: CONSOLE_OUT_ready = !full. A byte is captured on CONSOLE_OUT_valid & CONSOLE_OUT_ready.
- Capture FIFO: COUT_POP when empty is ignored. Simultaneous capture and pop on a full FIFO both succeed.
- All FIFO pointers are log2(depth)+1 bits wide and wrap naturally.

Optional Feature:
- Macro: WRAPPER_STIM_LOOP_EN.
- When defined: an extra input LOOP (1 bit). If LOOP=1 when the last step expires, the FSM reloads step 0 on the same edge, emits a one-cycle DONE pulse per pass, keeps BUSY=1, and continues until ABORT.
- When undefined: the LOOP port does not exist and replay is single-pass.

Decomposition:
- Package wrapper_stim_pkg: FSM state encoding (IDLE, HOLD, DONE), the TBL_DATA field offsets, and a clog2 constant function.
- Sub-module: stim_fifo (parameterised width/depth sync FIFO with push, pop, full, empty). It is instantiated twice, once for console input and once for capture.

Test Plan:
- Reset: assert RESETn=0 mid-HOLD -> DIP=0, PB=0, BUSY=0 immediately (asynchronous); FIFOs empty; CONSOLE_OUT_ready=1.
- Schedule: write step0={hold=41,DIP=0x001A}, step1={hold=60,DIP=0x001D}, STEP_COUNT=2, START -> DIP=0x1A for exactly 41 cycles, then 0x1D for 60 cycles, DONE pulses once, BUSY low, DIP stays 0x1D.
- Hold zero and abort:
  - step with hold=0 -> visible for exactly 1 cycle.
  - ABORT at cycle 10 of a 41-cycle hold -> IDLE next edge, DIP retained, no DONE.
- Console input: push 0x41,0x42,0x43; DUT acks every other cycle -> bytes delivered in order with valid held until ack; push 9 bytes into depth 8 -> CIN_OVF=1, 9th byte lost.
- Console output: DUT sends 8 bytes with no pops -> CONSOLE_OUT_ready=0 after the 8th; a simultaneous pop and valid on full captures the byte; pops return the bytes in order.
- Loop (macro on): LOOP=1 with 2 steps of hold 3 -> period 6, DONE pulse every 6 cycles, BUSY stays 1 until ABORT.
